weight_fetch_ctrl: RTL and testbench
====================================

# weight_fetch_ctrl

Read-side sequencer for the 28-lane neuron weight RAM array. It sweeps a contiguous address range of the shared-address BRAM bank and issues one read per address. It absorbs the one-cycle BRAM read latency and presents each 28-byte word as a valid/ready stream to the MAC datapath. A 2-entry skid FIFO and credit-based issue give full throughput with no lost or duplicated words under backpressure.

## Interface
Parameters:
- ADDR_W, 11, width of the RAM array address bus
- DEPTH, 784, number of valid words per BRAM; addresses wrap at DEPTH
- LANES, 28, number of BRAM instances (neurons) read in parallel
- DATA_W, 8, bits per lane

Ports:
- CLK  in  1  single clock; all logic on the rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  launches a sweep when sampled high while idle
- BASE_ADDR  in  ADDR_W  first address of the sweep; latched on an accepted START
- LEN  in  ADDR_W+1  number of words to read; latched on an accepted START
- BUSY  out  1  high from the accepted START until DONE
- DONE  out  1  one-cycle pulse when the sweep completes
- MEM_EN  out  1  read enable to the RAM array; write enable is not driven by this block
- MEM_ADDR  out  ADDR_W  address to the RAM array
- MEM_RD_DATA  in  LANES*DATA_W  packed RAM outputs; lane 0 (DO_0) is at bits [7:0], lane 27 is at the MSBs
- OUT_VALID  out  1  stream word valid
- OUT_READY  in  1  downstream accepts the word
- OUT_DATA  out  LANES*DATA_W  stream word, same packing as MEM_RD_DATA
- OUT_INDEX  out  ADDR_W  word ordinal within the sweep, 0..LEN-1
- OUT_LAST  out  1  high with the word whose OUT_INDEX = LEN-1

## Operation
- States:
  - IDLE: waiting for START; no reads issued.
  - RUN: issuing reads and draining words.
  - IDLE + DONE: the DONE pulse is issued on the return edge to IDLE.
- IDLE -> RUN on START=1 with LEN>0. BASE_ADDR and LEN are latched, and the issue and output counters are cleared.
- START with LEN=0 goes straight to DONE=1 for one cycle, with no MEM_EN.
- START while BUSY is ignored.
- RUN -> IDLE on the OUT_VALID & OUT_READY handshake of the word with OUT_LAST=1. DONE=1 in the following cycle.
- Issue rule, combinational in RUN: MEM_EN=1 when both of these hold:
  - issued < LEN;
  - (fifo_occ + inflight − pop) < 2, where pop = OUT_VALID & OUT_READY this cycle.
- MEM_ADDR = (BASE_ADDR + issued) wrapped modulo DEPTH; for example, BASE_ADDR=783 followed by the next address gives 0. MEM_ADDR holds its value when MEM_EN=0.
- inflight is a 1-bit register, set to MEM_EN on each edge. When inflight=1, MEM_RD_DATA is pushed into the FIFO on the next edge.
- FIFO: 2 entries, first-in first-out. OUT_DATA, OUT_INDEX and OUT_LAST come from the head entry. The credit rule guarantees the FIFO never overflows.
- OUT_VALID/OUT_DATA/OUT_INDEX/OUT_LAST are stable while OUT_VALID=1 and OUT_READY=0.
- Every word is delivered exactly once, in address order.

## Timing
- Reset values:
  - State = IDLE.
  - BUSY, DONE, MEM_EN, OUT_VALID, OUT_LAST = 0.
  - MEM_ADDR, OUT_DATA, OUT_INDEX = 0.
  - FIFO is empty and inflight = 0.
- Reset applies immediately, including mid-sweep. In-flight and buffered words are discarded, and DONE is not pulsed.
- START is sampled at edge E0. Then:
  - BUSY=1 and MEM_EN=1 with MEM_ADDR=BASE_ADDR in the cycle after E0.
  - The BRAM samples the read at E1.
  - The data is pushed into the FIFO at E2.
  - OUT_VALID=1 after E2, i.e. 2 cycles of start latency.
- With OUT_READY held high, one word is delivered per cycle. The last word appears LEN+1 cycles after E0. DONE follows one cycle after its handshake, and BUSY falls with DONE.
- Under backpressure, at most 2 words are buffered or in flight. MEM_EN deasserts within the same cycle the credit condition fails, and resumes in the cycle a pop frees a credit.
- DONE and a new START in the same cycle: the START is accepted, since the block is IDLE. BUSY rises again in the next cycle.

## Test plan
- Basic sweep: BASE=0, LEN=4, OUT_READY=1.
  - MEM_ADDR 0,1,2,3 on 4 consecutive cycles.
  - OUT_INDEX 0..3 consecutive, starting 2 cycles after START.
  - OUT_LAST on index 3, then DONE one cycle later.
  - Each OUT_DATA lane k equals the byte of BRAM model k at that address.
- Backpressure: LEN=16, with OUT_READY toggled by a random 50% pattern.
  - All 16 words are received in order with no duplicates.
  - MEM_EN is never high while 2 words are held (occupancy plus in-flight).
  - OUT_DATA is stable while stalled.
- Wrap-around: BASE=782, LEN=4 gives MEM_ADDR 782, 783, 0, 1 and OUT_INDEX 0..3.
- Boundary starts:
  - LEN=0 gives DONE one cycle after START, with MEM_EN never high.
  - START while BUSY has no effect on the running sweep.
  - START in the DONE cycle launches a second sweep.
- Reset mid-sweep: assert RST at word 5 of LEN=20.
  - All outputs return to their reset values asynchronously, with no DONE.
  - A new START with BASE=10, LEN=2 then delivers addresses 10 and 11 only.
- Full throughput: LEN=784, OUT_READY=1.
  - Completes in exactly 786 cycles from START to the last handshake.
  - DONE falls at cycle 787.

Source files
------------

// File: rtl/weight_fetch_ctrl.sv
// Read sequencer for the weight RAM array: sweeps an address range with credit-limited
// issue and drains BRAM words through a 2-entry skid FIFO as a valid/ready stream.
module weight_fetch_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 784,
  parameter int LANES  = 28,
  parameter int DATA_W = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [ADDR_W-1:0]         BASE_ADDR,
  input  logic [ADDR_W:0]           LEN,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      MEM_EN,
  output logic [ADDR_W-1:0]         MEM_ADDR,
  input  logic [LANES*DATA_W-1:0]   MEM_RD_DATA,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [LANES*DATA_W-1:0]   OUT_DATA,
  output logic [ADDR_W-1:0]         OUT_INDEX,
  output logic                      OUT_LAST
);

  localparam int W  = LANES * DATA_W;
  localparam int CW = ADDR_W + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     len_q;
  logic [CW-1:0]     issued_q;
  logic [CW-1:0]     pushed_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic              inflight_q;
  logic              done_q;

  logic [W-1:0]      fifo_data [0:1];
  logic [ADDR_W-1:0] fifo_idx  [0:1];
  logic              fifo_last [0:1];
  logic              head_q;
  logic              tail_q;
  logic [1:0]        occ_q;

  logic              pop;
  logic              push;
  logic              last_pop;
  logic              start_go;
  logic              start_empty;
  logic [2:0]        held;
  logic              mem_en;
  logic              done_d;

  assign OUT_VALID = (occ_q != 2'd0);
  assign OUT_DATA  = fifo_data[head_q];
  assign OUT_INDEX = fifo_idx[head_q];
  assign OUT_LAST  = OUT_VALID & fifo_last[head_q];

  assign pop      = OUT_VALID & OUT_READY;
  assign push     = inflight_q;
  assign last_pop = pop & OUT_LAST;

  // Words committed after this cycle's pop: buffered plus the one the BRAM is returning.
  assign held = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign start_go    = (state_q == S_IDLE) & START & (LEN != '0);
  assign start_empty = (state_q == S_IDLE) & START & (LEN == '0);

  assign mem_en   = (state_q == S_RUN) & (issued_q < len_q) & (held < 3'd2);
  assign MEM_EN   = mem_en;
  assign MEM_ADDR = mem_en ? rd_ptr_q : addr_hold_q;
  assign BUSY     = (state_q == S_RUN);
  assign DONE     = done_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_go)    state_d = S_RUN;
        if (start_empty) done_d  = 1'b1;
      end
      S_RUN: begin
        if (last_pop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_q       <= '0;
      issued_q    <= '0;
      rd_ptr_q    <= '0;
      addr_hold_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= mem_en;
      if (start_go) begin
        len_q    <= LEN;
        issued_q <= '0;
        rd_ptr_q <= BASE_ADDR;
      end else if (mem_en) begin
        issued_q    <= issued_q + CW'(1);
        addr_hold_q <= rd_ptr_q;
        rd_ptr_q    <= (rd_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_W'(1);
      end
    end
  end

  // Index and last flag travel with the data so the head entry is self-describing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_idx[0]  <= '0;
      fifo_idx[1]  <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      occ_q        <= 2'd0;
      pushed_q     <= '0;
    end else begin
      if (start_go) begin
        pushed_q <= '0;
      end else if (push) begin
        fifo_data[tail_q] <= MEM_RD_DATA;
        fifo_idx[tail_q]  <= pushed_q[ADDR_W-1:0];
        fifo_last[tail_q] <= (pushed_q == len_q - CW'(1));
        tail_q            <= ~tail_q;
        pushed_q          <= pushed_q + CW'(1);
      end
      if (pop) head_q <= ~head_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Scoreboard bench for weight_fetch_ctrl: expected addresses and words are queued at START,
// a negedge monitor checks issue, credit, stream content, stall stability and DONE.
module tb_weight_fetch_ctrl;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 784;
  localparam int LANES  = 28;
  localparam int DATA_W = 8;
  localparam int W      = LANES * DATA_W;

  logic              CLK = 1'b0;
  logic              RST;
  logic              START;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic [ADDR_W:0]   LEN;
  logic              BUSY, DONE, MEM_EN, OUT_VALID, OUT_READY, OUT_LAST;
  logic [ADDR_W-1:0] MEM_ADDR, OUT_INDEX;
  logic [W-1:0]      MEM_RD_DATA = '0;
  logic [W-1:0]      OUT_DATA;

  weight_fetch_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LANES(LANES), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .MEM_EN(MEM_EN), .MEM_ADDR(MEM_ADDR),
    .MEM_RD_DATA(MEM_RD_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_INDEX(OUT_INDEX), .OUT_LAST(OUT_LAST)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int addr;
    int idx;
    bit last;
  } exp_t;

  int   addr_q[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  time  t0 = 0, t_first = 0, t_last = 0, exp_done_t = 0, exp_done_t0 = 0;
  bit   rand_ready = 0;

  function automatic logic [W-1:0] word_of(input int addr);
    logic [W-1:0] w;
    for (int k = 0; k < LANES; k++)
      w[k*DATA_W +: DATA_W] = 8'(addr * 13 + k * 41 + 7) ^ 8'(addr >> 4);
    return w;
  endfunction

  // 28 BRAM lanes with one-cycle read latency.
  always @(posedge CLK)
    if (MEM_EN) MEM_RD_DATA <= word_of(int'(MEM_ADDR));

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none t=%0t", name, $time);
  endtask

  always @(posedge CLK) begin
    #1;
    OUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor
  int           outstanding = 0;
  bit           stall_prev = 0;
  logic [W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_idx;
  logic         prev_last;
  logic         hs;
  exp_t         e;
  int           a;

  always @(negedge CLK) begin
    if (RST) begin
      outstanding = 0;
      stall_prev  = 0;
    end else begin
      hs = OUT_VALID && OUT_READY;
      if (stall_prev) begin
        chk("stall_valid", OUT_VALID, 1'b1);
        chk("stall_data", OUT_DATA, prev_data);
        chk("stall_index", OUT_INDEX, prev_idx);
        chk("stall_last", OUT_LAST, prev_last);
      end
      stall_prev = OUT_VALID && !OUT_READY;
      prev_data  = OUT_DATA;
      prev_idx   = OUT_INDEX;
      prev_last  = OUT_LAST;
      if (MEM_EN) begin
        chk("credit", ((outstanding - int'(hs)) < 2), 1'b1);
        if (addr_q.size() == 0) fail("extra_issue");
        else begin
          a = addr_q.pop_front();
          chk("mem_addr", MEM_ADDR, a[ADDR_W-1:0]);
        end
      end
      if (hs) begin
        if (exp_q.size() == 0) fail("extra_word");
        else begin
          e = exp_q.pop_front();
          chk("out_data", OUT_DATA, word_of(e.addr));
          chk("out_index", OUT_INDEX, e.idx[ADDR_W-1:0]);
          chk("out_last", OUT_LAST, e.last);
          if (e.idx == 0) t_first = $time + 5;
          if (e.last) begin
            t_last     = $time + 5;
            exp_done_t = $time + 10;
          end
        end
      end
      if ($time == exp_done_t || $time == exp_done_t0) begin
        chk("done", DONE, 1'b1);
        chk("busy_with_done", BUSY, 1'b0);
      end else if (DONE) fail("unexpected_done");
      outstanding = outstanding + int'(MEM_EN) - int'(hs);
    end
  end

  // Call at posedge+1; returns at posedge+1 just after E0.
  task automatic start_sweep(input int base, input int len, input bit accept);
    START     = 1'b1;
    BASE_ADDR = base[ADDR_W-1:0];
    LEN       = len[ADDR_W:0];
    if (accept)
      for (int i = 0; i < len; i++) begin
        addr_q.push_back((base + i) % DEPTH);
        exp_q.push_back('{(base + i) % DEPTH, i, (i == len - 1)});
      end
    @(posedge CLK);
    t0 = $time;
    #1;
    START = 1'b0;
    if (accept && len == 0) exp_done_t0 = t0 + 5;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) return;
    end
    fail({name, "_timeout"});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_done"}, DONE, 1'b0);
    chk({tag, "_mem_en"}, MEM_EN, 1'b0);
    chk({tag, "_mem_addr"}, MEM_ADDR, '0);
    chk({tag, "_out_valid"}, OUT_VALID, 1'b0);
    chk({tag, "_out_last"}, OUT_LAST, 1'b0);
    chk({tag, "_out_data"}, OUT_DATA, '0);
    chk({tag, "_out_index"}, OUT_INDEX, '0);
  endtask

  initial begin
    START = 1'b0; BASE_ADDR = '0; LEN = '0; OUT_READY = 1'b1;
    RST = 1'b0;
    #1 RST = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    idle(2);

    // basic sweep
    start_sweep(0, 4, 1);
    chk("basic_busy", BUSY, 1'b1);
    chk("basic_first_en", MEM_EN, 1'b1);
    chk("basic_first_addr", MEM_ADDR, 11'd0);
    wait_done(50, "basic");
    chk("basic_first_latency", t_first - t0, 30);
    chk("basic_last_latency", t_last - t0, 60);
    idle(2);

    // wrap-around
    start_sweep(782, 4, 1);
    wait_done(50, "wrap");
    idle(2);

    // backpressure
    rand_ready = 1;
    start_sweep(300, 16, 1);
    wait_done(500, "backpressure");
    rand_ready = 0;
    chk("bp_all_received", exp_q.size(), 0);
    idle(2);

    // zero length
    start_sweep(5, 0, 1);
    chk("len0_busy", BUSY, 1'b0);
    chk("len0_mem_en", MEM_EN, 1'b0);
    idle(3);

    // START while busy is ignored
    start_sweep(100, 10, 1);
    idle(3);
    start_sweep(200, 5, 0);
    wait_done(100, "busy_start");
    idle(2);

    // START in the DONE cycle
    start_sweep(400, 3, 1);
    wait_done(50, "chain_first");
    start_sweep(410, 2, 1);
    chk("chain_busy", BUSY, 1'b1);
    wait_done(50, "chain_second");
    idle(2);

    // reset mid-sweep
    start_sweep(50, 20, 1);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() <= 15) break;
      @(posedge CLK);
      #1;
    end
    #1 RST = 1'b1;
    #1 chk_reset_outputs("midreset");
    addr_q.delete();
    exp_q.delete();
    @(posedge CLK);
    #1 RST = 1'b0;
    idle(2);
    start_sweep(10, 2, 1);
    wait_done(50, "after_reset");
    chk("after_reset_drained", exp_q.size(), 0);
    idle(2);

    // full throughput
    start_sweep(0, DEPTH, 1);
    wait_done(1000, "full");
    chk("full_last_hs", t_last - t0, 7860);
    chk("full_done_rise", $time - t0, 7861);
    idle(1);
    chk("full_done_fall", DONE, 1'b0);
    idle(2);

    // random sweeps
    rand_ready = 1;
    for (int n = 0; n < 4; n++) begin
      start_sweep(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 30)), 1);
      wait_done(300, "random");
      idle(1);
    end
    rand_ready = 0;
    idle(2);

    chk("final_addr_q_empty", addr_q.size(), 0);
    chk("final_exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
